// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the MIPS hazard/sequencing controller.
// Holds register-address width, stage control encodings, md FSM states.
package hazard_ctrl_pkg;

    localparam int REG_AW      = 5;
    localparam int MUL_LAT_DEF = 5;
    localparam int DIV_LAT_DEF = 32;
    localparam int CNT_W_DEF   = 8;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic if_id_flush;
        logic id_ex_flush;
    } stage_ctl_t;

    localparam stage_ctl_t CTL_RESET    = '{1'b0, 1'b0, 1'b1, 1'b1};
    localparam stage_ctl_t CTL_REDIRECT = '{1'b1, 1'b1, 1'b1, 1'b1};
    localparam stage_ctl_t CTL_STALL    = '{1'b0, 1'b0, 1'b0, 1'b1};
    localparam stage_ctl_t CTL_RUN      = '{1'b1, 1'b1, 1'b0, 1'b0};

    function automatic logic src_hit(
        input logic              use_r,
        input logic [REG_AW-1:0] src,
        input logic [REG_AW-1:0] dst
    );
        return use_r && (src == dst);
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// ID/EX hazard inputs and stage-control outputs of the hazard controller.
// master = pipeline datapath side, slave = hazard_ctrl side.
interface hazard_ctrl_if;
    import hazard_ctrl_pkg::*;

    logic [REG_AW-1:0] rs_D;
    logic [REG_AW-1:0] rt_D;
    logic              use_rs_D;
    logic              use_rt_D;
    logic              md_use_D;
    logic [REG_AW-1:0] rd_E;
    logic              reg_write_E;
    logic              mem_to_reg_E;
    logic              md_start_E;
    logic              md_is_div_E;
    logic              redirect_E;

    logic              pc_en;
    logic              if_id_en;
    logic              if_id_flush;
    logic              id_ex_flush;
    logic              md_busy;
    logic              md_done;
    logic [31:0]       stall_cnt;

    modport master (
        output rs_D, rt_D, use_rs_D, use_rt_D, md_use_D,
        output rd_E, reg_write_E, mem_to_reg_E,
        output md_start_E, md_is_div_E, redirect_E,
        input  pc_en, if_id_en, if_id_flush, id_ex_flush,
        input  md_busy, md_done, stall_cnt
    );

    modport slave (
        input  rs_D, rt_D, use_rs_D, use_rt_D, md_use_D,
        input  rd_E, reg_write_E, mem_to_reg_E,
        input  md_start_E, md_is_div_E, redirect_E,
        output pc_en, if_id_en, if_id_flush, id_ex_flush,
        output md_busy, md_done, stall_cnt
    );

endinterface

// File: rtl/hazard_ctrl_md_busy_timer.sv
// Mult/div occupancy timer: IDLE -> BUSY (LAT-1 cycles) -> DONE pulse.
// Ports: clk, reset (sync high), start, is_div -> busy, done.
module md_busy_timer
    import hazard_ctrl_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int DIV_LAT = DIV_LAT_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic is_div,
    output logic busy,
    output logic done
);

    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] load_val;

    assign load_val = is_div ? DIV_LOAD : MUL_LOAD;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // A start seen while BUSY is dropped; decode stalls prevent it.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            MD_IDLE: begin
                if (start) begin
                    state_d = MD_BUSY;
                    cnt_d   = load_val;
                end
            end
            MD_BUSY: begin
                if (cnt_q == CNT_ONE) begin
                    state_d = MD_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            MD_DONE: begin
                if (start) begin
                    state_d = MD_BUSY;
                    cnt_d   = load_val;
                end else begin
                    state_d = MD_IDLE;
                end
            end
            default: begin
                state_d = MD_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign busy = (state_q == MD_BUSY);
    assign done = (state_q == MD_DONE);

    a_no_start_busy: assert property (
        @(posedge clk) disable iff (reset)
        !(start && state_q == MD_BUSY)
    );

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller: load-use / md stalls, EX redirect squash, stall count.
// Ports: clk, reset (sync high), hz (slave: ID/EX info in, stage ctl out).
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int DIV_LAT = DIV_LAT_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic         clk,
    input  logic         reset,
    hazard_ctrl_if.slave hz
);

    logic        load_use;
    logic        md_stall;
    logic        stall;
    logic        stall_take;
    logic        md_busy;
    logic        md_done;
    stage_ctl_t  ctl;
    logic [31:0] stall_cnt_q;

    md_busy_timer #(
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT),
        .CNT_W   (CNT_W)
    ) u_md_timer (
        .clk    (clk),
        .reset  (reset),
        .start  (hz.md_start_E),
        .is_div (hz.md_is_div_E),
        .busy   (md_busy),
        .done   (md_done)
    );

    // r0 is hardwired zero, so a load to it never hazards.
    assign load_use = hz.reg_write_E && hz.mem_to_reg_E &&
                      (hz.rd_E != '0) &&
                      (src_hit(hz.use_rs_D, hz.rs_D, hz.rd_E) ||
                       src_hit(hz.use_rt_D, hz.rt_D, hz.rd_E));

    // An md op entering the unit this cycle also blocks the next one.
    assign md_stall = hz.md_use_D && (md_busy || hz.md_start_E);
    assign stall    = load_use || md_stall;

    always_comb begin
        ctl        = CTL_RUN;
        stall_take = 1'b0;
        priority case (1'b1)
            reset:         ctl = CTL_RESET;
            hz.redirect_E: ctl = CTL_REDIRECT;
            stall: begin
                ctl        = CTL_STALL;
                stall_take = 1'b1;
            end
            default:       ctl = CTL_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else if (stall_take && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign hz.pc_en       = ctl.pc_en;
    assign hz.if_id_en    = ctl.if_id_en;
    assign hz.if_id_flush = ctl.if_id_flush;
    assign hz.id_ex_flush = ctl.id_ex_flush;
    assign hz.md_busy     = md_busy;
    assign hz.md_done     = md_done;
    assign hz.stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed scenarios then random traffic.
// Expected outputs come from a cycle-indexed behavioural model.
module tb_hazard_ctrl;

    localparam int MUL = 5;
    localparam int DIV = 32;

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
        logic       use_rs;
        logic       use_rt;
        logic       md_use;
        logic       reg_write;
        logic       mem_to_reg;
        logic       md_start;
        logic       md_is_div;
        logic       redirect;
        logic       reset;
    } stim_t;

    typedef struct packed {
        logic        pc_en;
        logic        if_id_en;
        logic        if_id_flush;
        logic        id_ex_flush;
        logic        md_busy;
        logic        md_done;
        logic [31:0] stall_cnt;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    hazard_ctrl_if hz ();

    hazard_ctrl #(
        .MUL_LAT (MUL),
        .DIV_LAT (DIV),
        .CNT_W   (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz)
    );

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    // Model: md op occupies the unit for cycles (st, st+lat), done at st+lat.
    int          cyc    = 0;
    bit          md_act = 0;
    int          md_st  = 0;
    int          md_lat = 0;
    logic [31:0] m_cnt  = 32'd0;

    function automatic bit m_busy();
        return md_act && (cyc > md_st) && (cyc < md_st + md_lat);
    endfunction

    function automatic bit m_done();
        return md_act && (cyc == md_st + md_lat);
    endfunction

    task automatic step(input stim_t s);
        exp_t e;
        bit   lu, ms, taken;
        @(posedge clk);
        #1;
        reset           = s.reset;
        hz.rs_D         = s.rs;
        hz.rt_D         = s.rt;
        hz.rd_E         = s.rd;
        hz.use_rs_D     = s.use_rs;
        hz.use_rt_D     = s.use_rt;
        hz.md_use_D     = s.md_use;
        hz.reg_write_E  = s.reg_write;
        hz.mem_to_reg_E = s.mem_to_reg;
        hz.md_start_E   = s.md_start;
        hz.md_is_div_E  = s.md_is_div;
        hz.redirect_E   = s.redirect;

        lu = s.reg_write && s.mem_to_reg && (s.rd != 5'd0) &&
             ((s.use_rs && s.rs == s.rd) || (s.use_rt && s.rt == s.rd));
        ms = s.md_use && (m_busy() || s.md_start);
        taken = 0;
        e.md_busy   = m_busy();
        e.md_done   = m_done();
        e.stall_cnt = m_cnt;
        if (s.reset) begin
            {e.pc_en, e.if_id_en, e.if_id_flush, e.id_ex_flush} = 4'b0011;
        end else if (s.redirect) begin
            {e.pc_en, e.if_id_en, e.if_id_flush, e.id_ex_flush} = 4'b1111;
        end else if (lu || ms) begin
            {e.pc_en, e.if_id_en, e.if_id_flush, e.id_ex_flush} = 4'b0001;
            taken = 1;
        end else begin
            {e.pc_en, e.if_id_en, e.if_id_flush, e.id_ex_flush} = 4'b1100;
        end
        exp_q.push_back(e);

        if (s.reset) begin
            md_act = 0;
            m_cnt  = 32'd0;
        end else begin
            if (taken && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
            if (s.md_start) begin
                md_act = 1;
                md_st  = cyc;
                md_lat = s.md_is_div ? DIV : MUL;
            end
        end
        cyc++;
    endtask

    task automatic chk(input string n, input logic [31:0] a,
                       input logic [31:0] x);
        checks++;
        if (a !== x) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", n, $time, a, x);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("pc_en",       {31'd0, hz.pc_en},       {31'd0, e.pc_en});
                chk("if_id_en",    {31'd0, hz.if_id_en},    {31'd0, e.if_id_en});
                chk("if_id_flush", {31'd0, hz.if_id_flush}, {31'd0, e.if_id_flush});
                chk("id_ex_flush", {31'd0, hz.id_ex_flush}, {31'd0, e.id_ex_flush});
                chk("md_busy",     {31'd0, hz.md_busy},     {31'd0, e.md_busy});
                chk("md_done",     {31'd0, hz.md_done},     {31'd0, e.md_done});
                chk("stall_cnt",   hz.stall_cnt,            e.stall_cnt);
            end
        end
    end

    function automatic stim_t rnd();
        stim_t s;
        s.rs         = 5'($urandom_range(0, 3));
        s.rt         = 5'($urandom_range(0, 3));
        s.rd         = 5'($urandom_range(0, 3));
        s.use_rs     = 1'($urandom_range(0, 1));
        s.use_rt     = 1'($urandom_range(0, 1));
        s.md_use     = 1'($urandom_range(0, 1));
        s.reg_write  = 1'($urandom_range(0, 1));
        s.mem_to_reg = 1'($urandom_range(0, 1));
        s.md_start   = !m_busy() && ($urandom_range(0, 5) == 0);
        s.md_is_div  = ($urandom_range(0, 3) == 0);
        s.redirect   = ($urandom_range(0, 7) == 0);
        s.reset      = ($urandom_range(0, 79) == 0);
        return s;
    endfunction

    initial begin
        stim_t s;
        reset           = 1'b1;
        hz.rs_D         = '0;
        hz.rt_D         = '0;
        hz.rd_E         = '0;
        hz.use_rs_D     = 1'b0;
        hz.use_rt_D     = 1'b0;
        hz.md_use_D     = 1'b0;
        hz.reg_write_E  = 1'b0;
        hz.mem_to_reg_E = 1'b0;
        hz.md_start_E   = 1'b0;
        hz.md_is_div_E  = 1'b0;
        hz.redirect_E   = 1'b0;

        s = '0; s.reset = 1; step(s); step(s);
        s = '0; step(s);

        s = '0; s.reg_write = 1; s.mem_to_reg = 1;
        s.rd = 5'd8; s.use_rs = 1; s.rs = 5'd8; step(s);
        s.rd = 5'd0; s.rs = 5'd0; step(s);
        s.rd = 5'd8; s.rs = 5'd8; s.redirect = 1; step(s);

        s = '0; s.md_start = 1; s.md_is_div = 1; s.md_use = 1; step(s);
        s.md_start = 0; s.md_is_div = 0;
        repeat (DIV) step(s);

        s = '0; s.md_start = 1; step(s);
        s.md_start = 0; repeat (MUL - 1) step(s);
        s.md_start = 1; step(s);
        s.md_start = 0; repeat (MUL + 1) step(s);

        s = '0; s.md_start = 1; s.md_is_div = 1; step(s);
        s = '0; repeat (21) step(s);
        s.reset = 1; step(s);
        s = '0; repeat (40) step(s);

        @(negedge clk);
        #1;
        force dut.stall_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.stall_cnt_q;
        m_cnt = 32'hFFFF_FFFE;
        s = '0; s.reg_write = 1; s.mem_to_reg = 1;
        s.rd = 5'd3; s.use_rt = 1; s.rt = 5'd3;
        repeat (3) step(s);
        s = '0; step(s);

        repeat (1500) step(rnd());

        for (int i = 0; i < 5 && exp_q.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left, required 0",
                     exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
